quad_decoder_param: RTL and testbench
=====================================

Name: quad_decoder_param

Overview:
- Parametrised quadrature decoder for the lock machine's rotary encoder input.
- Synchronises and debounces raw A/B, decodes Gray-code phase transitions in x1/x2/x4 mode, and maintains a signed position counter with wrap or saturate.
- Also provides a direction flag, a one-cycle step strobe and a sticky illegal-transition flag.
- Feeds the combination-entry logic in place of the fixed 2-bit direction output.

Parameters:
- CNT_W, 8, position counter width in bits (signed two's complement), valid range 2..32.
- FILT_LEN, 4, consecutive stable synchronised samples required before a filtered input changes, valid range 1..255.
- SAT, 0, 0 = counter wraps at limits; 1 = counter saturates at signed max/min.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-low.
- EN  in  1  count enable.
- A  in  1  raw encoder phase A, asynchronous.
- B  in  1  raw encoder phase B, asynchronous.
- MODE  in  2  00 = x4, 01 = x2, 10 = x1, 11 = x4.
- CLR  in  1  synchronous counter clear.
- LOAD  in  1  synchronous counter load.
- LOAD_VAL  in  CNT_W  value loaded when LOAD is high.
- ERR_CLR  in  1  clears ERR.
- COUNT  out  CNT_W  signed position.
- DIR  out  1  direction of last counted step: 1 = forward, 0 = reverse.
- STEP  out  1  one-cycle pulse for each counted step.
- ERR  out  1  sticky illegal-transition flag.

Behaviour:
- Reset (RST = 0 at a CLK edge): COUNT = 0, DIR = 0, STEP = 0, ERR = 0, sync/filter registers = 0, filter counters = 0, PRIMED = 0.
- Synchroniser: 2-FF synchroniser per input. A change is visible at the sync output 2 edges after the edge that first samples it.
- Filter, per input:
  - Counter increments while sync output != filtered value; resets to 0 when they are equal.
  - When the counter reaches FILT_LEN, the filtered value takes the sync value on that edge and the counter resets.
- Priming: after reset, PRIMED = 0.
  - First time both filter counters are 0 and FILT_LEN cycles have elapsed, the phase reference {A_f,B_f} is loaded with the current filtered value and PRIMED is set.
  - No counting and no ERR until PRIMED = 1.
- Phase sequence, {A,B}: forward is 00 -> 01 -> 11 -> 10 -> 00; reverse is the opposite order.
- Decode each cycle, comparing the new filtered pair against the previous one:
  - Unchanged: no action.
  - One bit changed: a valid step, forward or reverse per the sequence.
  - Both bits changed: illegal. ERR set to 1, no count, DIR unchanged.
- Mode gating of valid steps:
  - x4: every valid step counts.
  - x2: only steps where A changes count.
  - x1: only 01 -> 11 (forward) and 11 -> 01 (reverse) count.
- A counted step updates COUNT by ±1, sets DIR, and pulses STEP high for exactly 1 cycle.
- Latency: raw input edge to COUNT/STEP update is FILT_LEN + 3 cycles when the input stays stable.
- EN = 0: sync, filter and phase reference keep tracking; no count, no STEP, DIR held. Illegal transitions still set ERR. Re-enabling produces no phantom step.
- Counter priority: RST > CLR > LOAD > step. A step coincident with CLR or LOAD is discarded and STEP stays 0. CLR gives COUNT = 0; LOAD gives COUNT = LOAD_VAL.
- Limits, SAT = 0: max + 1 wraps to min; min - 1 wraps to max.
- Limits, SAT = 1:
  - COUNT holds at max/min.
  - STEP still pulses and DIR still updates on a counted step at the limit.
- ERR_CLR clears ERR. If an illegal transition occurs in the same cycle, set wins and ERR stays 1.
- MODE may change at any time and takes effect on the next decoded transition. It does not affect the phase reference.
- Reset asserted mid-operation: all state returns to reset values on that edge and priming restarts.

Test Plan:
- Reset release with A = B = 1, FILT_LEN = 4, then one full forward cycle 11 -> 10 -> 00 -> 01 -> 11, inputs held 10 cycles per phase, MODE = x4 -> no ERR after priming; COUNT = -4?
  - No: 11 -> 10 is a forward step, so COUNT = 4, DIR = 1, 4 STEP pulses. Check the first STEP arrives FILT_LEN + 3 = 7 cycles after the first raw edge.
- Same forward cycle in x2 -> COUNT = 2; in x1 -> COUNT = 1. Reverse cycle 00 -> 10 -> 11 -> 01 -> 00 in x1 -> returns to 0, DIR = 0.
- Glitch: A pulses high for 3 cycles with FILT_LEN = 4 -> no filter change, COUNT unchanged, no STEP.
- Illegal 00 -> 11 with both bits changing together -> ERR = 1, COUNT unchanged. ERR_CLR together with a second illegal jump -> ERR stays 1. ERR_CLR alone -> ERR = 0.
- CNT_W = 4: LOAD_VAL = 7, then one forward x4 step -> SAT = 0 gives COUNT = -8; SAT = 1 gives COUNT = 7 with STEP = 1.
- LOAD and CLR asserted together in the cycle of a decoded step -> COUNT = 0, STEP = 0. EN = 0 across 3 steps, then EN = 1 -> COUNT unchanged and no step on re-enable.

Source files
------------

// File: rtl/quad_decoder_param.sv
// Quadrature decoder: 2-FF sync + per-input stability filter, Gray-code decode in
// x1/x2/x4, signed position counter with wrap or saturate, step strobe and sticky error.
module qd_filter #(
    parameter int FILT_LEN = 4,
    parameter int FW       = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic filt_o,
    output logic busy_o
);
    logic          s1_q, s2_q, filt_q;
    logic [FW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
            if (s2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == FW'(FILT_LEN - 1)) begin
                filt_q <= s2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + FW'(1);
            end
        end
    end

    assign filt_o = filt_q;
    assign busy_o = (cnt_q != '0);
endmodule

module quad_decoder_param #(
    parameter int CNT_W    = 8,
    parameter int FILT_LEN = 4,
    parameter int SAT      = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             A,
    input  logic             B,
    input  logic [1:0]       MODE,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [CNT_W-1:0] LOAD_VAL,
    input  logic             ERR_CLR,
    output logic [CNT_W-1:0] COUNT,
    output logic             DIR,
    output logic             STEP,
    output logic             ERR
);
    localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CMIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [1:0] raw, filt, busy;
    assign raw = {A, B};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_filt
            qd_filter #(.FILT_LEN(FILT_LEN), .FW(FW)) u_filt (
                .clk_i  (CLK),
                .rst_n_i(RST),
                .raw_i  (raw[g]),
                .filt_o (filt[g]),
                .busy_o (busy[g])
            );
        end
    endgenerate

    logic [1:0]       ref_q;
    logic             primed_q;
    logic [FW-1:0]    el_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d, step_q, step_d, err_q, err_d;

    // Gray phase index 00,01,11,10 -> 0..3, so forward is index+1 mod 4
    logic [1:0] chg, pos_cur, pos_prev;
    logic       valid, illegal, fwd, mode_ok, counted, prime_go;

    assign chg      = filt ^ ref_q;
    assign pos_cur  = {filt[1], filt[1] ^ filt[0]};
    assign pos_prev = {ref_q[1], ref_q[1] ^ ref_q[0]};
    assign fwd      = (pos_cur == pos_prev + 2'd1);
    assign valid    = primed_q && (chg == 2'b01 || chg == 2'b10);
    assign illegal  = primed_q && (chg == 2'b11);
    assign prime_go = !primed_q && (el_q == FW'(FILT_LEN)) && (busy == 2'b00);

    always_comb begin
        case (MODE)
            2'b01:   mode_ok = chg[1];
            2'b10:   mode_ok = (ref_q == 2'b01 && filt == 2'b11) ||
                               (ref_q == 2'b11 && filt == 2'b01);
            default: mode_ok = 1'b1;
        endcase
    end

    assign counted = valid && mode_ok && EN;

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;
        if (ERR_CLR) err_d = 1'b0;
        if (illegal) err_d = 1'b1;
        if (CLR) begin
            count_d = '0;
        end else if (LOAD) begin
            count_d = LOAD_VAL;
        end else if (counted) begin
            dir_d  = fwd;
            step_d = 1'b1;
            if (fwd) begin
                if (!(SAT != 0 && count_q == CMAX)) count_d = count_q + CNT_W'(1);
            end else begin
                if (!(SAT != 0 && count_q == CMIN)) count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ref_q    <= 2'b00;
            primed_q <= 1'b0;
            el_q     <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (el_q != FW'(FILT_LEN)) el_q <= el_q + FW'(1);
            if (primed_q || prime_go) ref_q <= filt;
            if (prime_go) primed_q <= 1'b1;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign COUNT = count_q;
    assign DIR   = dir_q;
    assign STEP  = step_q;
    assign ERR   = err_q;
endmodule

// File: tb/tb_quad_decoder_param.sv
// Directed bench for quad_decoder_param: 8-bit wrap instance plus 4-bit wrap and
// 4-bit saturate instances sharing the same stimulus.
module tb_quad_decoder_param;
    logic       CLK = 1'b0, RST = 1'b0, EN = 1'b1, A = 1'b1, B = 1'b1;
    logic       CLR = 1'b0, LOAD = 1'b0, ERR_CLR = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [7:0] LOAD_VAL = 8'd0;

    logic [7:0] cnt8;
    logic [3:0] cnt_w, cnt_s;
    logic       dir8, step8, err8, dir_w, step_w, err_w, dir_s, step_s, err_s;

    quad_decoder_param #(.CNT_W(8), .FILT_LEN(4), .SAT(0)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .A(A), .B(B), .MODE(MODE), .CLR(CLR),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .ERR_CLR(ERR_CLR),
        .COUNT(cnt8), .DIR(dir8), .STEP(step8), .ERR(err8));

    quad_decoder_param #(.CNT_W(4), .FILT_LEN(4), .SAT(0)) dut_w (
        .CLK(CLK), .RST(RST), .EN(EN), .A(A), .B(B), .MODE(MODE), .CLR(CLR),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL[3:0]), .ERR_CLR(ERR_CLR),
        .COUNT(cnt_w), .DIR(dir_w), .STEP(step_w), .ERR(err_w));

    quad_decoder_param #(.CNT_W(4), .FILT_LEN(4), .SAT(1)) dut_s (
        .CLK(CLK), .RST(RST), .EN(EN), .A(A), .B(B), .MODE(MODE), .CLR(CLR),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL[3:0]), .ERR_CLR(ERR_CLR),
        .COUNT(cnt_s), .DIR(dir_s), .STEP(step_s), .ERR(err_s));

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0, nsteps = 0;
    always @(posedge CLK) if (step8) nsteps <= nsteps + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    typedef struct {
        logic [1:0] ab;
        logic [1:0] mode;
        logic       en;
        int         cnt;
        logic       dir;
        int         dsteps;
    } vec_t;

    vec_t tbl[24];
    int   s0;

    initial begin
        // x4 forward, x2 forward, x1 forward, x1 reverse, x4 (MODE=11) reverse, EN gating
        tbl[0]  = '{2'b00, 2'b00, 1'b1, 2, 1'b1, 1};
        tbl[1]  = '{2'b01, 2'b00, 1'b1, 3, 1'b1, 1};
        tbl[2]  = '{2'b11, 2'b00, 1'b1, 4, 1'b1, 1};
        tbl[3]  = '{2'b10, 2'b01, 1'b1, 4, 1'b1, 0};
        tbl[4]  = '{2'b00, 2'b01, 1'b1, 5, 1'b1, 1};
        tbl[5]  = '{2'b01, 2'b01, 1'b1, 5, 1'b1, 0};
        tbl[6]  = '{2'b11, 2'b01, 1'b1, 6, 1'b1, 1};
        tbl[7]  = '{2'b10, 2'b10, 1'b1, 6, 1'b1, 0};
        tbl[8]  = '{2'b00, 2'b10, 1'b1, 6, 1'b1, 0};
        tbl[9]  = '{2'b01, 2'b10, 1'b1, 6, 1'b1, 0};
        tbl[10] = '{2'b11, 2'b10, 1'b1, 7, 1'b1, 1};
        tbl[11] = '{2'b01, 2'b10, 1'b1, 6, 1'b0, 1};
        tbl[12] = '{2'b00, 2'b10, 1'b1, 6, 1'b0, 0};
        tbl[13] = '{2'b10, 2'b10, 1'b1, 6, 1'b0, 0};
        tbl[14] = '{2'b11, 2'b10, 1'b1, 6, 1'b0, 0};
        tbl[15] = '{2'b01, 2'b10, 1'b1, 5, 1'b0, 1};
        tbl[16] = '{2'b00, 2'b10, 1'b1, 5, 1'b0, 0};
        tbl[17] = '{2'b10, 2'b11, 1'b1, 4, 1'b0, 1};
        tbl[18] = '{2'b11, 2'b11, 1'b1, 3, 1'b0, 1};
        tbl[19] = '{2'b01, 2'b00, 1'b0, 3, 1'b0, 0};
        tbl[20] = '{2'b00, 2'b00, 1'b0, 3, 1'b0, 0};
        tbl[21] = '{2'b10, 2'b00, 1'b0, 3, 1'b0, 0};
        tbl[22] = '{2'b10, 2'b00, 1'b1, 3, 1'b0, 0};
        tbl[23] = '{2'b00, 2'b00, 1'b1, 4, 1'b1, 1};

        cyc(3);
        chk("reset_count", int'(cnt8), 0);
        chk("reset_dir", int'(dir8), 0);
        chk("reset_step", int'(step8), 0);
        chk("reset_err", int'(err8), 0);

        RST = 1'b1;
        cyc(20);
        chk("prime_err", int'(err8), 0);
        chk("prime_count", int'(cnt8), 0);

        // first raw edge 11->10: STEP must land exactly 7 cycles later
        {A, B} = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 6) chk("lat_early", int'(step8), 0);
            if (k == 7) chk("lat_step", int'(step8), 1);
        end
        cyc(3);
        chk("lat_count", int'(cnt8), 1);
        chk("lat_dir", int'(dir8), 1);

        for (int i = 0; i < 24; i++) begin
            {A, B} = tbl[i].ab;
            MODE   = tbl[i].mode;
            EN     = tbl[i].en;
            s0     = nsteps;
            cyc(10);
            chk($sformatf("vec%0d_count", i), int'($signed(cnt8)), tbl[i].cnt);
            chk($sformatf("vec%0d_dir", i), int'(dir8), int'(tbl[i].dir));
            chk($sformatf("vec%0d_steps", i), nsteps - s0, tbl[i].dsteps);
            chk($sformatf("vec%0d_err", i), int'(err8), 0);
        end

        // 3-cycle glitch on A is shorter than the filter
        s0 = nsteps;
        A = 1'b1; cyc(3); A = 1'b0; cyc(12);
        chk("glitch_count", int'(cnt8), 4);
        chk("glitch_steps", nsteps - s0, 0);
        chk("glitch_err", int'(err8), 0);

        // illegal 00->11
        s0 = nsteps;
        {A, B} = 2'b11; cyc(10);
        chk("illegal_err", int'(err8), 1);
        chk("illegal_count", int'(cnt8), 4);
        chk("illegal_steps", nsteps - s0, 0);

        // ERR_CLR held through a second illegal jump: set wins on the decode edge
        {A, B} = 2'b00; ERR_CLR = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 6) chk("errclr_before", int'(err8), 0);
        end
        ERR_CLR = 1'b0;
        cyc(2);
        chk("err_set_wins", int'(err8), 1);
        ERR_CLR = 1'b1; cyc(1); ERR_CLR = 1'b0;
        chk("err_clr_alone", int'(err8), 0);
        chk("err_count", int'(cnt8), 4);

        // CLR+LOAD on the decode edge of a forward step
        s0 = nsteps;
        {A, B} = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 6) begin CLR = 1'b1; LOAD = 1'b1; LOAD_VAL = 8'd50; end
            if (k == 7) begin
                chk("lc_count", int'(cnt8), 0);
                chk("lc_step", int'(step8), 0);
                CLR = 1'b0; LOAD = 1'b0;
            end
        end
        cyc(3);
        chk("lc_steps", nsteps - s0, 0);
        chk("lc_hold", int'(cnt8), 0);

        // positive limit on the 4-bit instances
        LOAD_VAL = 8'd7; LOAD = 1'b1; cyc(1); LOAD = 1'b0;
        chk("load_main", int'(cnt8), 7);
        chk("load_w", int'($signed(cnt_w)), 7);
        chk("load_s", int'($signed(cnt_s)), 7);
        {A, B} = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 7) begin
                chk("wrap_hi_count", int'($signed(cnt_w)), -8);
                chk("wrap_hi_step", int'(step_w), 1);
                chk("sat_hi_count", int'($signed(cnt_s)), 7);
                chk("sat_hi_step", int'(step_s), 1);
                chk("sat_hi_dir", int'(dir_s), 1);
                chk("main_hi_count", int'($signed(cnt8)), 8);
            end
        end
        cyc(3);

        // negative limit: 11->01 is a reverse step
        LOAD_VAL = 8'hF8; LOAD = 1'b1; cyc(1); LOAD = 1'b0;
        {A, B} = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 7) begin
                chk("wrap_lo_count", int'($signed(cnt_w)), 7);
                chk("sat_lo_count", int'($signed(cnt_s)), -8);
                chk("sat_lo_step", int'(step_s), 1);
                chk("sat_lo_dir", int'(dir_s), 0);
                chk("main_lo_count", int'($signed(cnt8)), -9);
            end
        end
        cyc(3);

        // mid-operation reset, then priming restarts from the held 01 phase
        RST = 1'b0; cyc(1);
        chk("midrst_count", int'(cnt8), 0);
        chk("midrst_sat_count", int'(cnt_s), 0);
        RST = 1'b1; cyc(20);
        chk("reprime_err", int'(err8), 0);
        {A, B} = 2'b11; cyc(10);
        chk("reprime_count", int'(cnt8), 1);
        chk("reprime_dir", int'(dir8), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
